sync_fifo_param: RTL and testbench

- Parametrised successor to the team's single-clock FIFO, for use as a buffer between pipeline stages on one clock.
- Additions over the previous generation:
  - occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - overflow and underflow error pulses;
  - read-valid strobe;
  - simultaneous read and write accepted when the FIFO is full;
  - optional first-word-fall-through (FWFT) read mode.

---
 rtl/sync_fifo_pkg.sv | 11 +
 rtl/sync_fifo_mem.sv | 33 +++
 rtl/sync_fifo_param.sv | 88 ++++++++
 tb/tb_sync_fifo_param.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default sizes, pointer-width helper and configuration check for sync_fifo_param
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  function automatic int ptr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic bit cfg_ok(input int depth, input int afull_th, input int aempty_th);
    return depth >= 2 && (depth & (depth - 1)) == 0 && aempty_th >= 0 && aempty_th < afull_th && afull_th <= depth;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port array with registered (REG_READ=1) or combinational read
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PTR_WIDTH = 4,
  parameter bit REG_READ = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we,
  input  logic [PTR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [PTR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end
  if (REG_READ) begin : g_reg
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk_i) begin
      if (rst_i) q <= '0;
      else if (re) q <= mem[raddr];
    end
    assign rdata = q;
  end else begin : g_comb
    logic unused_ok;
    assign unused_ok = &{1'b0, re, rst_i};
    assign rdata = mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, thresholds, error pulses; define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_WIDTH = ptr_width(DEPTH),
  parameter int AFULL_TH = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 write_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic                 full_out,
  output logic                 almost_full_out,
  output logic                 wr_err_out,
  input  logic                 read_en_i,
  output logic [WIDTH-1:0]     rdata_out,
  output logic                 rvalid_out,
  output logic                 empty_out,
  output logic                 almost_empty_out,
  output logic                 rd_err_out,
  output logic [PTR_WIDTH:0]   count_out
);
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit REG_READ = 1'b0;
`else
  localparam bit REG_READ = 1'b1;
`endif
  localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_AF = (PTR_WIDTH+1)'(AFULL_TH);
  localparam logic [PTR_WIDTH:0] CNT_AE = (PTR_WIDTH+1)'(AEMPTY_TH);
  if (!cfg_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
    $error("sync_fifo_param: DEPTH must be a power of 2 >= 2 and 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0] count, count_nxt;
  logic rd_ok, wr_ok;
  assign empty_out = count == '0;
  assign full_out = count == CNT_FULL;
  assign almost_full_out = count >= CNT_AF;
  assign almost_empty_out = count <= CNT_AE;
  assign count_out = count;
  assign rd_ok = read_en_i & ~empty_out;
  assign wr_ok = write_en_i & (~full_out | rd_ok);
  assign count_nxt = count + (PTR_WIDTH+1)'(wr_ok) - (PTR_WIDTH+1)'(rd_ok);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wr_err_out <= 1'b0;
      rd_err_out <= 1'b0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + PTR_WIDTH'(1) : wr_ptr;
      rd_ptr <= rd_ok ? rd_ptr + PTR_WIDTH'(1) : rd_ptr;
      count <= count_nxt;
      wr_err_out <= write_en_i & ~wr_ok;
      rd_err_out <= read_en_i & ~rd_ok;
    end
  end
  if (REG_READ) begin : g_rv
    logic rvalid_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) rvalid_q <= 1'b0;
      else rvalid_q <= rd_ok;
    end
    assign rvalid_out = rvalid_q;
  end else begin : g_fwft
    assign rvalid_out = ~empty_out;
  end
  sync_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_WIDTH(PTR_WIDTH),
    .REG_READ(REG_READ)
  ) u_mem (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata(wdata_i),
    .re(rd_ok),
    .raddr(rd_ptr),
    .rdata(rdata_out)
  );
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized scoreboard bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;
  localparam int W = 32;
  localparam int D = 16;
  localparam int PW = 4;
  localparam int AF = 14;
  localparam int AE = 2;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic write_en_i = 1'b0;
  logic read_en_i = 1'b0;
  logic [W-1:0] wdata_i = '0;
  logic full_out, almost_full_out, wr_err_out, rvalid_out, empty_out, almost_empty_out, rd_err_out;
  logic [W-1:0] rdata_out;
  logic [PW:0] count_out;
  sync_fifo_param #(
    .WIDTH(W),
    .DEPTH(D),
    .PTR_WIDTH(PW),
    .AFULL_TH(AF),
    .AEMPTY_TH(AE)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .write_en_i(write_en_i),
    .wdata_i(wdata_i),
    .full_out(full_out),
    .almost_full_out(almost_full_out),
    .wr_err_out(wr_err_out),
    .read_en_i(read_en_i),
    .rdata_out(rdata_out),
    .rvalid_out(rvalid_out),
    .empty_out(empty_out),
    .almost_empty_out(almost_empty_out),
    .rd_err_out(rd_err_out),
    .count_out(count_out)
  );
  always #5 clk_i = ~clk_i;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rd = '0;
  bit exp_wr_err = 1'b0;
  bit exp_rd_err = 1'b0;
  bit exp_rvalid = 1'b0;
  bit mon_en = 1'b0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic we, input logic [W-1:0] wd, input logic re, input logic rst = 1'b0);
    bit rok, wok;
    write_en_i = we;
    wdata_i = wd;
    read_en_i = re;
    rst_i = rst;
    rok = re && model_q.size() > 0;
    wok = we && (model_q.size() < D || rok);
    @(posedge clk_i);
    #1;
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      last_rd = '0;
      exp_wr_err = 1'b0;
      exp_rd_err = 1'b0;
      exp_rvalid = 1'b0;
    end else begin
      exp_wr_err = we && !wok;
      exp_rd_err = re && !rok;
      exp_rvalid = rok;
      if (rok) begin
        last_rd = model_q.pop_front();
        exp_q.push_back(last_rd);
      end
      if (wok) model_q.push_back(wd);
    end
    write_en_i = 1'b0;
    read_en_i = 1'b0;
    rst_i = 1'b0;
  endtask
  always @(negedge clk_i) begin
    int n;
    if (mon_en) begin
      n = model_q.size();
      chk("count", W'(count_out), W'(n));
      chk("empty", W'(empty_out), W'(n == 0));
      chk("full", W'(full_out), W'(n == D));
      chk("almost_full", W'(almost_full_out), W'(n >= AF));
      chk("almost_empty", W'(almost_empty_out), W'(n <= AE));
      chk("wr_err", W'(wr_err_out), W'(exp_wr_err));
      chk("rd_err", W'(rd_err_out), W'(exp_rd_err));
`ifdef SYNC_FIFO_FWFT_EN
      chk("rvalid", W'(rvalid_out), W'(n > 0));
      if (n > 0) chk("rdata_fwft", rdata_out, model_q[0]);
`else
      chk("rvalid", W'(rvalid_out), W'(exp_rvalid));
      if (rvalid_out) begin
        if (exp_q.size() == 0) chk("rvalid_unexpected", W'(rvalid_out), '0);
        else chk("rdata", rdata_out, exp_q.pop_front());
      end else chk("rdata_hold", rdata_out, last_rd);
`endif
    end
  end
  initial begin
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    mon_en = 1'b1;
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset_rdata", rdata_out, '0);
`endif
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0);
    chk("fill_count", W'(count_out), 32'd16);
    step(1'b1, 32'h11, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0);
    step(1'b1, 32'hAA, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b1, 32'h55, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, 1'b0);
      step(1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 150; i++) step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);
    step(1'b1, $urandom, 1'b1, 1'b1);
    chk("mid_reset_count", W'(count_out), '0);
    chk("mid_reset_empty", W'(empty_out), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("mid_reset_rdata", rdata_out, '0);
`endif
    for (int i = 0; i < 200; i++) step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h77, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
